// File: rtl/serializer_param_fifo.sv
// Purpose: parametrised parallel-to-serial converter; DATA_W-bit words are queued in a
//          DEPTH-entry FIFO and shifted out LANES bits per clock, MSB- or LSB-first per word.
// Latency: a word accepted into an empty FIFO with the shifter idle pops on the next edge;
//          beat k is valid after edge N+1+k.
// Backpressure: ready_out = (level < DEPTH) from the registered level only; a pop on the same
//          edge does not reopen ready_out until the following cycle.
//
// Ports:
//   clk_serial    in   single clock for all logic
//   rst_n         in   asynchronous active-low reset
//   data_in       in   parallel word, DATA_W bits
//   msb_first     in   bit order for this word, stored alongside it
//   valid_in      in   data_in/msb_first valid
//   ready_out     out  FIFO can accept a word
//   serial_out    out  current beat, LANES bits, registered
//   serial_valid  out  serial_out carries a data beat, registered
//   frame_start   out  high on beat 0 of each word, registered
//   level         out  FIFO occupancy in words (word in the shifter not counted)

// Small generic FIFO: registered occupancy, head visible combinationally.
// Storage is not reset; only pointers and level are.
module serializer_param_fifo_buf #(
   parameter int W     = 65,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               wdat,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   assign head = mem[rd_ptr];
endmodule

module serializer_param_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int LANES  = 1
) (
   input  logic                     clk_serial,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     msb_first,
   input  logic                     valid_in,
   output logic                     ready_out,
   output logic [LANES-1:0]         serial_out,
   output logic                     serial_valid,
   output logic                     frame_start,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int BEATS = DATA_W / LANES;
   localparam int CW    = $clog2(BEATS) + 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   word_q, word_nxt;
   logic                msb_q, msb_nxt;
   logic [CW-1:0]       beat_cnt, cnt_nxt;
   logic [LANES-1:0]    out_nxt;
   logic                vld_nxt;
   logic                fs_nxt;

   logic                push;
   logic                pop;
   logic [DATA_W:0]     head;
   logic [DATA_W-1:0]   head_word;
   logic                head_msb;

   // Beat k of a word; in both orders higher lanes carry higher-numbered word bits,
   // only the beat-to-slice order is reversed.
   function automatic logic [LANES-1:0] beat_of(input logic [DATA_W-1:0] w,
                                                input logic msb, input int k);
      int idx;
      idx = msb ? (BEATS - 1 - k) : k;
      return w[idx*LANES +: LANES];
   endfunction

   assign ready_out = (level < LW'(DEPTH));
   assign push      = valid_in && ready_out;
   assign head_word = head[DATA_W-1:0];
   assign head_msb  = head[DATA_W];

   serializer_param_fifo_buf #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_buf (
      .clk   (clk_serial),
      .rst_n (rst_n),
      .push  (push),
      .wdat  ({msb_first, data_in}),
      .pop   (pop),
      .head  (head),
      .level (level)
   );

   always_ff @(posedge clk_serial or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         word_q       <= '0;
         msb_q        <= 1'b0;
         beat_cnt     <= '0;
         serial_out   <= '0;
         serial_valid <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         state        <= state_nxt;
         word_q       <= word_nxt;
         msb_q        <= msb_nxt;
         beat_cnt     <= cnt_nxt;
         serial_out   <= out_nxt;
         serial_valid <= vld_nxt;
         frame_start  <= fs_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word_q;
      msb_nxt   = msb_q;
      cnt_nxt   = beat_cnt;
      out_nxt   = '0;
      vld_nxt   = 1'b0;
      fs_nxt    = 1'b0;
      pop       = 1'b0;

      case (state)
         IDLE: begin
            // level only reflects pushes from earlier edges, so a word pushed on
            // this edge is picked up on the next one.
            if (level != '0) begin
               pop       = 1'b1;
               word_nxt  = head_word;
               msb_nxt   = head_msb;
               out_nxt   = beat_of(head_word, head_msb, 0);
               vld_nxt   = 1'b1;
               fs_nxt    = 1'b1;
               cnt_nxt   = CW'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (beat_cnt < CW'(BEATS)) begin
               out_nxt = beat_of(word_q, msb_q, int'(beat_cnt));
               vld_nxt = 1'b1;
               cnt_nxt = beat_cnt + CW'(1);
            end else if (level != '0) begin
               // Last beat already on the output: chain straight into the next word.
               pop      = 1'b1;
               word_nxt = head_word;
               msb_nxt  = head_msb;
               out_nxt  = beat_of(head_word, head_msb, 0);
               vld_nxt  = 1'b1;
               fs_nxt   = 1'b1;
               cnt_nxt  = CW'(1);
            end else begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_serializer_param_fifo.sv
module tb_serializer_param_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [63:0] data_a;
   logic        msb_a, valid_a, ready_a, so_a, sv_a, fs_a;
   logic [2:0]  level_a;
   logic [15:0] data_b;
   logic        msb_b, valid_b, ready_b, sv_b, fs_b;
   logic [3:0]  so_b;
   logic [2:0]  level_b;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_qa[$];
   logic [4:0] exp_qb[$];

   serializer_param_fifo #(.DATA_W(64), .DEPTH(4), .LANES(1)) u_dut_a (
      .clk_serial(clk), .rst_n(rst_n), .data_in(data_a), .msb_first(msb_a),
      .valid_in(valid_a), .ready_out(ready_a), .serial_out(so_a),
      .serial_valid(sv_a), .frame_start(fs_a), .level(level_a));

   serializer_param_fifo #(.DATA_W(16), .DEPTH(4), .LANES(4)) u_dut_b (
      .clk_serial(clk), .rst_n(rst_n), .data_in(data_b), .msb_first(msb_b),
      .valid_in(valid_b), .ready_out(ready_b), .serial_out(so_b),
      .serial_valid(sv_b), .frame_start(fs_b), .level(level_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: expected {frame_start, beat} per word, from the bench's own bit-order model.
   task automatic exp_word_a(input logic [63:0] w, input logic m);
      for (int k = 0; k < 64; k++) exp_qa.push_back({k == 0, m ? w[63-k] : w[k]});
   endtask

   task automatic exp_word_b(input logic [15:0] w, input logic m);
      logic [15:0] s;
      for (int k = 0; k < 4; k++) begin
         s = m ? (w >> (12 - 4*k)) : (w >> (4*k));
         exp_qb.push_back({k == 0, s[3:0]});
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (sv_a) begin
            chk("a_sb_has_entry", 64'(exp_qa.size() > 0), 64'd1);
            if (exp_qa.size() > 0) chk("a_beat", 64'({fs_a, so_a}), 64'(exp_qa.pop_front()));
         end else begin
            chk("a_idle_out", 64'({fs_a, so_a}), 64'd0);
         end
         if (sv_b) begin
            chk("b_sb_has_entry", 64'(exp_qb.size() > 0), 64'd1);
            if (exp_qb.size() > 0) chk("b_beat", 64'({fs_b, so_b}), 64'(exp_qb.pop_front()));
         end else begin
            chk("b_idle_out", 64'({fs_b, so_b}), 64'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Returns just after the accepting edge.
   task automatic push_a(input logic [63:0] w, input logic m);
      int n;
      n = 0;
      data_a = w; msb_a = m; valid_a = 1'b1;
      while (ready_a !== 1'b1 && n < 500) begin tick(1); n++; end
      chk("a_push_ready_wait", 64'(n < 500), 64'd1);
      exp_word_a(w, m);
      tick(1);
      valid_a = 1'b0;
   endtask

   task automatic push_b(input logic [15:0] w, input logic m);
      int n;
      n = 0;
      data_b = w; msb_b = m; valid_b = 1'b1;
      while (ready_b !== 1'b1 && n < 500) begin tick(1); n++; end
      chk("b_push_ready_wait", 64'(n < 500), 64'd1);
      exp_word_b(w, m);
      tick(1);
      valid_b = 1'b0;
   endtask

   task automatic drain_a(input string tag);
      int n;
      n = 0;
      while ((exp_qa.size() != 0 || sv_a) && n < 2000) begin tick(1); n++; end
      chk(tag, 64'(n < 2000), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] cap;
      logic [15:0] cap16;
      logic [7:0]  first8;
      int          fs_cnt, cnt, n, vcnt;

      rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      data_a = '0; data_b = '0; msb_a = 1'b0; msb_b = 1'b0;
      tick(3);
      chk("rst_a_out", 64'({sv_a, fs_a, so_a}), 64'd0);
      chk("rst_a_level", 64'(level_a), 64'd0);
      chk("rst_a_ready", 64'(ready_a), 64'd1);
      chk("rst_b_out", 64'({sv_b, fs_b, so_b}), 64'd0);
      chk("rst_b_ready", 64'(ready_b), 64'd1);
      rst_n = 1'b1;
      tick(2);

      // MSB-first single word, timing and bit order.
      push_a(64'hA5A5_0000_FFFF_1234, 1'b1);
      chk("t1_no_beat_at_accept", 64'(sv_a), 64'd0);
      chk("t1_level_after_push", 64'(level_a), 64'd1);
      tick(1);
      chk("t1_beat0_valid", 64'({sv_a, fs_a}), 64'b11);
      chk("t1_level_after_pop", 64'(level_a), 64'd0);
      cap = '0; fs_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         cap = {cap[62:0], so_a};
         fs_cnt += int'(fs_a);
         tick(1);
      end
      chk("t1_word_bits", cap, 64'hA5A5_0000_FFFF_1234);
      chk("t1_frame_starts", 64'(fs_cnt), 64'd1);
      chk("t1_valid_drops", 64'(sv_a), 64'd0);

      // LSB-first word followed by a second word with no gap.
      push_a(64'hA5A5_0000_FFFF_1234, 1'b0);
      push_a(64'h0123_4567_89AB_CDEF, 1'b1);
      chk("t2_level_pushpop", 64'(level_a), 64'd1);
      cnt = 0; fs_cnt = 0; first8 = '0;
      while (sv_a && cnt < 300) begin
         if (cnt < 8) first8 = {first8[6:0], so_a};
         fs_cnt += int'(fs_a);
         cnt++;
         tick(1);
      end
      chk("t2_lsb_first8", 64'(first8), 64'b0010_1100);
      chk("t2_gapless_beats", 64'(cnt), 64'd128);
      chk("t2_frame_starts", 64'(fs_cnt), 64'd2);

      // Fill: five words taken, sixth waits for the next pop.
      for (int i = 0; i < 5; i++)
         push_a(64'(i + 1) * 64'h0101_0101_0101_0101 ^ 64'h00FF_0F0F_3C3C_5A5A, 1'(i));
      chk("t3_full_level", 64'(level_a), 64'd4);
      chk("t3_full_ready", 64'(ready_a), 64'd0);
      n = 0;
      while (ready_a !== 1'b1 && n < 200) begin tick(1); n++; end
      chk("t3_ready_return_cycles", 64'(n), 64'd61);
      chk("t3_level_after_pop", 64'(level_a), 64'd3);
      push_a(64'hFEDC_BA98_7654_3210, 1'b0);
      drain_a("t3_drain");

      // Push on the same edge as a pop at level DEPTH-1.
      for (int i = 0; i < 4; i++) push_a(64'h1357_9BDF_0246_8ACE + 64'(i), 1'b1);
      chk("t4_level3", 64'(level_a), 64'd3);
      tick(61);
      chk("t4_before_level", 64'(level_a), 64'd3);
      data_a = 64'hC0FF_EE00_1234_5678; msb_a = 1'b0; valid_a = 1'b1;
      chk("t4_before_ready", 64'(ready_a), 64'd1);
      exp_word_a(data_a, msb_a);
      tick(1);
      valid_a = 1'b0;
      chk("t4_pop_happened", 64'(fs_a), 64'd1);
      chk("t4_level_same", 64'(level_a), 64'd3);
      chk("t4_ready_stays", 64'(ready_a), 64'd1);
      drain_a("t4_drain");

      // Four-lane instance, both orders.
      push_b(16'h1234, 1'b1);
      chk("t5_no_beat_at_accept", 64'(sv_b), 64'd0);
      tick(1);
      cap16 = '0;
      for (int k = 0; k < 4; k++) begin cap16 = {cap16[11:0], so_b}; tick(1); end
      chk("t5_msb_nibbles", 64'(cap16), 64'h1234);
      chk("t5_valid_drops", 64'(sv_b), 64'd0);
      push_b(16'h1234, 1'b0);
      tick(1);
      cap16 = '0;
      for (int k = 0; k < 4; k++) begin cap16 = {cap16[11:0], so_b}; tick(1); end
      chk("t5_lsb_nibbles", 64'(cap16), 64'h4321);
      chk("t5_b_empty", 64'(exp_qb.size()), 64'd0);

      // Reset in the middle of a word.
      push_a(64'h8000_0000_0000_0001, 1'b1);
      push_a(64'h1111_2222_3333_4444, 1'b0);
      push_a(64'h5555_6666_7777_8888, 1'b1);
      tick(19);
      chk("t6_level_before_rst", 64'(level_a), 64'd2);
      chk("t6_shifting_before_rst", 64'(sv_a), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_out", 64'({sv_a, fs_a, so_a}), 64'd0);
      chk("t6_rst_level", 64'(level_a), 64'd0);
      chk("t6_rst_ready", 64'(ready_a), 64'd1);
      exp_qa.delete();
      exp_qb.delete();
      tick(2);
      rst_n = 1'b1;
      vcnt = 0;
      repeat (20) begin vcnt += int'(sv_a); tick(1); end
      chk("t6_no_stale_beats", 64'(vcnt), 64'd0);
      push_a(64'hDEAD_BEEF_0BAD_F00D, 1'b1);
      chk("t6_no_beat_at_accept", 64'(sv_a), 64'd0);
      tick(1);
      chk("t6_beat0_after_accept", 64'({sv_a, fs_a}), 64'b11);
      drain_a("t6_drain");

      chk("end_a_empty", 64'(exp_qa.size()), 64'd0);
      chk("end_b_empty", 64'(exp_qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
